// File: rtl/alu_sequencer.sv
// Command sequencer in front of a combinational ALU: queues commands, drives registered
// operands for SETTLE cycles, captures a held response and maintains a chaining accumulator.
module alu_sequencer #(
  parameter int DEPTH  = 4,
  parameter int SETTLE = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [3:0]  cmd_op,
  input  logic [15:0] cmd_a,
  input  logic [15:0] cmd_b,
  input  logic        cmd_use_acc,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_result,
  output logic [1:0]  rsp_err,
  output logic [3:0]  rsp_op,
  output logic [15:0] alu_a,
  output logic [15:0] alu_b,
  output logic [3:0]  alu_op,
  input  logic [31:0] alu_result,
  input  logic [1:0]  alu_err,
  output logic        busy,
  output logic [31:0] acc
);

  // Handshakes: a transfer happens on a rising edge where valid && ready; the
  // offering side holds its payload stable until then. cmd_ready depends only on
  // the FIFO count, and rsp_* hold steady while rsp_valid && !rsp_ready.

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_SETTLE = 2'd1;
  localparam logic [1:0] S_RESP   = 2'd2;

  localparam int AW = $clog2(DEPTH);
  localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  logic [1:0]    state;
  logic [CW-1:0] cnt;

  logic [3:0]    q_op     [DEPTH];
  logic [15:0]   q_a      [DEPTH];
  logic [15:0]   q_b      [DEPTH];
  logic          q_use_acc[DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;

  logic          fifo_empty;
  logic          fifo_full;
  logic          push;
  logic          load;
  logic [3:0]    head_op;
  logic [15:0]   head_a;
  logic [15:0]   head_b;
  logic          head_use_acc;
  logic          head_legal;
  logic [1:0]    cap_err;

  assign fifo_empty   = (count == '0);
  assign fifo_full    = (count == (AW+1)'(DEPTH));
  assign cmd_ready    = !fifo_full;
  assign push         = cmd_valid && cmd_ready;
  assign head_op      = q_op[rd_ptr];
  assign head_a       = q_a[rd_ptr];
  assign head_b       = q_b[rd_ptr];
  assign head_use_acc = q_use_acc[rd_ptr];
  assign head_legal   = (head_op <= 4'd4);
  // A load both pops the FIFO and starts the next command, from IDLE or straight out of RESP.
  assign load         = !fifo_empty && ((state == S_IDLE) || ((state == S_RESP) && rsp_ready));
  assign busy         = (state != S_IDLE) || !fifo_empty;

  // Division by zero is flagged here even if the ALU itself does not report it.
  assign cap_err = {alu_err[1] | (((alu_op == 4'd3) || (alu_op == 4'd4)) && (alu_b == 16'd0)),
                    alu_err[0]};

  always_ff @(posedge clk) begin
    if (push) begin
      q_op[wr_ptr]      <= cmd_op;
      q_a[wr_ptr]       <= cmd_a;
      q_b[wr_ptr]       <= cmd_b;
      q_use_acc[wr_ptr] <= cmd_use_acc;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (load) rd_ptr <= rd_ptr + AW'(1);
      case ({push, load})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      cnt        <= '0;
      alu_a      <= '0;
      alu_b      <= '0;
      alu_op     <= '0;
      rsp_valid  <= 1'b0;
      rsp_result <= '0;
      rsp_err    <= '0;
      rsp_op     <= '0;
      acc        <= '0;
    end else if (load) begin
      if (head_legal) begin
        alu_op    <= head_op;
        alu_b     <= head_b;
        alu_a     <= head_use_acc ? acc[15:0] : head_a;
        cnt       <= CW'(SETTLE - 1);
        rsp_valid <= 1'b0;
        state     <= S_SETTLE;
      end else begin
        // Illegal opcodes never reach the ALU; the operand registers keep their values.
        rsp_result <= '0;
        rsp_err    <= 2'b11;
        rsp_op     <= head_op;
        rsp_valid  <= 1'b1;
        state      <= S_RESP;
      end
    end else begin
      case (state)
        S_IDLE: ;
        S_SETTLE: begin
          if (cnt != '0) begin
            cnt <= cnt - CW'(1);
          end else begin
            rsp_result <= alu_result;
            rsp_op     <= alu_op;
            rsp_err    <= cap_err;
            rsp_valid  <= 1'b1;
            if (cap_err == 2'b00) acc <= alu_result;
            state      <= S_RESP;
          end
        end
        S_RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer with a behavioural ALU attached to its operand outputs.
module tb_alu_sequencer;

  logic        clk;
  logic        rst_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [3:0]  cmd_op;
  logic [15:0] cmd_a;
  logic [15:0] cmd_b;
  logic        cmd_use_acc;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_result;
  logic [1:0]  rsp_err;
  logic [3:0]  rsp_op;
  logic [15:0] alu_a;
  logic [15:0] alu_b;
  logic [3:0]  alu_op;
  logic [31:0] alu_result;
  logic [1:0]  alu_err;
  logic        busy;
  logic [31:0] acc;

  int vectors;
  int miscompares;

  alu_sequencer #(.DEPTH(4), .SETTLE(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_use_acc(cmd_use_acc),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
    .rsp_err(rsp_err), .rsp_op(rsp_op),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .alu_result(alu_result), .alu_err(alu_err),
    .busy(busy), .acc(acc)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Behavioural ALU; sub borrow reports err[0], divide by zero reports nothing.
  always_comb begin
    alu_result = '0;
    alu_err    = '0;
    case (alu_op)
      4'd0: alu_result = {16'b0, alu_a} + {16'b0, alu_b};
      4'd1: begin
        alu_result = {16'b0, alu_a} - {16'b0, alu_b};
        alu_err[0] = (alu_a < alu_b);
      end
      4'd2: alu_result = {16'b0, alu_a} * {16'b0, alu_b};
      4'd3: if (alu_b != 16'd0) alu_result = {16'b0, alu_a / alu_b};
      4'd4: if (alu_b != 16'd0) alu_result = {16'b0, alu_a % alu_b};
      default: alu_err = 2'b01;
    endcase
  end

  // Driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                      input logic ua, input int max_wait, output bit ok);
    cmd_op      = op;
    cmd_a       = a;
    cmd_b       = b;
    cmd_use_acc = ua;
    cmd_valid   = 1'b1;
    ok          = 1'b0;
    for (int i = 0; i < max_wait && !ok; i++) begin
      if (cmd_ready) ok = 1'b1;
      step();
    end
    cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp(output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (!rsp_valid && n < 20);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_op = '0; cmd_a = '0; cmd_b = '0;
    cmd_use_acc = 1'b0; rsp_ready = 1'b0;
    step(); step();
    vectors++; if (cmd_ready !== 1'b1) begin miscompares++; $display("FAIL reset_cmd_ready got %0b want 1", cmd_ready); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy got %0b want 0", busy); end
    vectors++; if (rsp_valid !== 1'b0) begin miscompares++; $display("FAIL reset_rsp_valid got %0b want 0", rsp_valid); end
    vectors++; if ({rsp_result, rsp_err, rsp_op} !== 38'd0) begin miscompares++; $display("FAIL reset_rsp got %h/%b/%0d want 0", rsp_result, rsp_err, rsp_op); end
    vectors++; if ({alu_a, alu_b, alu_op, acc} !== 68'd0) begin miscompares++; $display("FAIL reset_alu_acc got %h %h %h %h want 0", alu_a, alu_b, alu_op, acc); end
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_add();
    bit ok; int n;
    rsp_ready = 1'b1;
    push(4'd0, 16'd11, 16'd15, 1'b0, 10, ok);
    vectors++; if (ok !== 1'b1) begin miscompares++; $display("FAIL add_accept got %0b want 1", ok); end
    wait_rsp(n);
    vectors++; if (n !== 3) begin miscompares++; $display("FAIL add_latency got %0d want 3", n); end
    vectors++; if (rsp_result !== 32'd26) begin miscompares++; $display("FAIL add_result got %0d want 26", rsp_result); end
    vectors++; if (rsp_err !== 2'b00) begin miscompares++; $display("FAIL add_err got %b want 00", rsp_err); end
    vectors++; if (rsp_op !== 4'd0) begin miscompares++; $display("FAIL add_op got %0d want 0", rsp_op); end
    vectors++; if (acc !== 32'd26) begin miscompares++; $display("FAIL add_acc got %0d want 26", acc); end
    step(); step();
  endtask

  task automatic test_chain();
    bit ok; int n;
    push(4'd2, 16'd11, 16'd15, 1'b0, 10, ok);
    push(4'd0, 16'hdead, 16'd10, 1'b1, 10, ok);
    wait_rsp(n);
    vectors++; if (rsp_result !== 32'd165) begin miscompares++; $display("FAIL chain_mul got %0d want 165", rsp_result); end
    vectors++; if (rsp_op !== 4'd2) begin miscompares++; $display("FAIL chain_mul_op got %0d want 2", rsp_op); end
    wait_rsp(n);
    vectors++; if (n !== 3) begin miscompares++; $display("FAIL chain_gap got %0d want 3", n); end
    vectors++; if (rsp_result !== 32'd175) begin miscompares++; $display("FAIL chain_add got %0d want 175", rsp_result); end
    vectors++; if (alu_a !== 16'd165) begin miscompares++; $display("FAIL chain_alu_a got %0d want 165", alu_a); end
    vectors++; if (acc !== 32'd175) begin miscompares++; $display("FAIL chain_acc got %0d want 175", acc); end
    step(); step();
  endtask

  task automatic test_div_error();
    bit ok; int n;
    push(4'd3, 16'd11, 16'd0, 1'b0, 10, ok);
    wait_rsp(n);
    vectors++; if (n !== 3) begin miscompares++; $display("FAIL div0_latency got %0d want 3", n); end
    vectors++; if (rsp_err !== 2'b10) begin miscompares++; $display("FAIL div0_err got %b want 10", rsp_err); end
    vectors++; if (acc !== 32'd175) begin miscompares++; $display("FAIL div0_acc got %0d want 175", acc); end
    step();
    push(4'd0, 16'd1, 16'd0, 1'b1, 10, ok);
    wait_rsp(n);
    vectors++; if (alu_a !== 16'd175) begin miscompares++; $display("FAIL div0_next_alu_a got %0d want 175", alu_a); end
    vectors++; if (rsp_result !== 32'd175) begin miscompares++; $display("FAIL div0_next_result got %0d want 175", rsp_result); end
    step();
    push(4'd1, 16'd3, 16'd5, 1'b0, 10, ok);
    wait_rsp(n);
    vectors++; if (rsp_err !== 2'b01) begin miscompares++; $display("FAIL sub_err got %b want 01", rsp_err); end
    vectors++; if (rsp_result !== 32'hffff_fffe) begin miscompares++; $display("FAIL sub_result got %h want fffffffe", rsp_result); end
    vectors++; if (acc !== 32'd175) begin miscompares++; $display("FAIL sub_acc got %0d want 175", acc); end
    step(); step();
  endtask

  task automatic test_illegal();
    bit ok; int n;
    push(4'd7, 16'd9, 16'd9, 1'b0, 10, ok);
    wait_rsp(n);
    vectors++; if (n !== 1) begin miscompares++; $display("FAIL ill_latency got %0d want 1", n); end
    vectors++; if (rsp_result !== 32'd0) begin miscompares++; $display("FAIL ill_result got %0d want 0", rsp_result); end
    vectors++; if (rsp_err !== 2'b11) begin miscompares++; $display("FAIL ill_err got %b want 11", rsp_err); end
    vectors++; if (rsp_op !== 4'd7) begin miscompares++; $display("FAIL ill_op got %0d want 7", rsp_op); end
    vectors++; if ({alu_op, alu_a, alu_b} !== {4'd1, 16'd3, 16'd5}) begin miscompares++; $display("FAIL ill_alu_hold got %0d %0d %0d want 1 3 5", alu_op, alu_a, alu_b); end
    vectors++; if (acc !== 32'd175) begin miscompares++; $display("FAIL ill_acc got %0d want 175", acc); end
    step(); step();
  endtask

  task automatic test_back_to_back();
    bit ok; int n; int accepted;
    rsp_ready = 1'b0;
    accepted  = 0;
    for (int i = 0; i < 5; i++) begin
      push(4'd0, 16'(i + 1), 16'd100, 1'b0, 10, ok);
      if (ok) accepted++;
    end
    vectors++; if (accepted !== 5) begin miscompares++; $display("FAIL b2b_accepted got %0d want 5", accepted); end
    vectors++; if (cmd_ready !== 1'b0) begin miscompares++; $display("FAIL b2b_full got %0b want 0", cmd_ready); end
    push(4'd0, 16'd6, 16'd100, 1'b0, 3, ok);
    vectors++; if (ok !== 1'b0) begin miscompares++; $display("FAIL b2b_sixth got %0b want 0", ok); end
    vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL b2b_busy got %0b want 1", busy); end
    vectors++; if ({rsp_valid, rsp_result} !== {1'b1, 32'd101}) begin miscompares++; $display("FAIL b2b_held got %0b/%0d want 1/101", rsp_valid, rsp_result); end
    rsp_ready = 1'b1;
    for (int k = 1; k < 5; k++) begin
      wait_rsp(n);
      vectors++; if (n !== 3) begin miscompares++; $display("FAIL b2b_gap%0d got %0d want 3", k, n); end
      vectors++; if (rsp_result !== 32'(101 + k)) begin miscompares++; $display("FAIL b2b_order%0d got %0d want %0d", k, rsp_result, 101 + k); end
    end
    step();
    vectors++; if ({busy, rsp_valid} !== 2'b00) begin miscompares++; $display("FAIL b2b_drain got %b want 00", {busy, rsp_valid}); end
    vectors++; if (acc !== 32'd105) begin miscompares++; $display("FAIL b2b_acc got %0d want 105", acc); end
    step();
  endtask

  task automatic test_reset_mid();
    bit ok; bit seen;
    rsp_ready = 1'b1;
    push(4'd0, 16'd1, 16'd2, 1'b0, 10, ok);
    push(4'd0, 16'd3, 16'd4, 1'b0, 10, ok);
    push(4'd0, 16'd5, 16'd6, 1'b0, 10, ok);
    vectors++; if ({busy, rsp_valid} !== 2'b10) begin miscompares++; $display("FAIL mid_pre got %b want 10", {busy, rsp_valid}); end
    rst_n = 1'b0;
    #1;
    vectors++; if ({busy, rsp_valid, cmd_ready} !== 3'b001) begin miscompares++; $display("FAIL mid_flags got %b want 001", {busy, rsp_valid, cmd_ready}); end
    vectors++; if ({rsp_result, rsp_err, rsp_op} !== 38'd0) begin miscompares++; $display("FAIL mid_rsp got %h/%b/%0d want 0", rsp_result, rsp_err, rsp_op); end
    vectors++; if ({alu_a, alu_b, alu_op, acc} !== 68'd0) begin miscompares++; $display("FAIL mid_alu_acc got %h %h %h %h want 0", alu_a, alu_b, alu_op, acc); end
    step(); step();
    rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (rsp_valid || busy) seen = 1'b1;
    end
    vectors++; if (seen !== 1'b0) begin miscompares++; $display("FAIL mid_after got %0b want 0", seen); end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    test_reset();
    test_add();
    test_chain();
    test_div_error();
    test_illegal();
    test_back_to_back();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
